// File: rtl/aes_pkg.sv
// Package for the AES-192 inverse key schedule.
// Holds the S-box and round-constant tables, the j%6==0 / j/6 lookup tables
// for word indices 0..63, the word_t type, the FSM state type and small helpers.
// Optional feature macro: AES_INV_KEY_MIXCOL_EN (adds inv_mix_column).
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Forward S-box; byte 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // RCON[i] for i = j/6; only 1..8 are reachable for AES-192.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef logic [63:0]      j_flag_tab_t;
    typedef logic [63:0][3:0] j_div_tab_t;

    // Evaluated at elaboration only: the datapath just indexes the tables.
    function automatic j_flag_tab_t build_j_mod6_is0();
        j_flag_tab_t t;
        t = '0;
        for (int j = 0; j < 64; j++) t[j] = (j % 6 == 0);
        return t;
    endfunction

    function automatic j_div_tab_t build_j_div6();
        j_div_tab_t t;
        t = '0;
        for (int j = 0; j < 64; j++) t[j] = 4'(j / 6);
        return t;
    endfunction

    localparam j_flag_tab_t J_MOD6_IS0 = build_j_mod6_is0();
    localparam j_div_tab_t  J_DIV6     = build_j_div6();

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic word_t rot_word(input word_t x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic word_t sub_word(input word_t x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

`ifdef AES_INV_KEY_MIXCOL_EN
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; byte 0 of the column is x[31:24].
    function automatic word_t inv_mix_column(input word_t x);
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = x[31 - 8 * i -: 8];
            m2[i] = xtime(a[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

endpackage

// File: rtl/aes_inv_word_gen_192.sv
// One step of the inverse AES-192 word recurrence (combinational):
//   w[j-6] = w[j] ^ T(w[j-1], j)
//   T(x, j) = SubWord(RotWord(x)) ^ {RCON[j/6], 24'h0} when j%6 == 0, else x.
// Ports:
//   j      in  6   index of w_j
//   w_j    in  32  w[j]
//   w_jm1  in  32  w[j-1]
//   w_jm6  out 32  w[j-6]
module aes_inv_word_gen_192
    import aes_pkg::*;
(
    input  logic [5:0] j,
    input  word_t      w_j,
    input  word_t      w_jm1,
    output word_t      w_jm6
);

    word_t t;

    always_comb begin
        t = w_jm1;
        if (J_MOD6_IS0[j]) begin
            t = sub_word(rot_word(w_jm1)) ^ {RCON[J_DIV6[j]], 24'h000000};
        end
    end

    assign w_jm6 = w_j ^ t;

endmodule

// File: rtl/aes_inv_keyexpansion_192.sv
// Reverse AES-192 key schedule. From the last six expanded words w46..w51 it
// regenerates round keys RK12 down to RK0, one per accepted handshake, so the
// inverse cipher needs no full 52-word key store.
// Optional feature macro: AES_INV_KEY_MIXCOL_EN -- round keys 11..1 are passed
// through InvMixColumns (equivalent inverse cipher); RK12, RK0 stay raw.
// Ports:
//   clk, reset  clock (rising edge), synchronous active-high reset
//   start       1-cycle pulse in IDLE; samples last_key
//   last_key    {w46,w47,w48,w49,w50,w51}, w46 in [191:160]
//   key_ready   consumer accepts round_key this cycle
//   round_key   {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96]
//   round_idx   r of round_key, 12 down to 0
//   key_valid   round_key/round_idx valid
//   busy        sequence in progress (FSM is in RUN; start ignored)
//   done        1-cycle pulse after RK0 is accepted
// Handshake: a key transfers on a rising edge where key_valid and key_ready are
// both high. While key_valid is high and key_ready low, round_key, round_idx
// and key_valid hold unchanged; key_valid never drops without a transfer.
module aes_inv_keyexpansion_192
    import aes_pkg::*;
#(
    parameter int NR = 12,
    parameter int NK = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [191:0] last_key,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    if (NR != 12 || NK != 6) begin : g_cfg_check
        $error("aes_inv_keyexpansion_192 supports only NR=12, NK=6");
    end

    state_t           state, state_nx;
    logic [0:5][31:0] window, window_nx;   // window[i] = w[k+i]
    logic [5:0]       k, k_nx;
    logic [127:0]     key_nx, raw_key;
    logic [3:0]       idx_nx;
    logic             valid_nx, done_nx;
    logic             fire;
    word_t            gen_w [4];           // gen_w[i] = w[k-1-i]

    assign fire = key_valid & key_ready;
    assign busy = (state == S_RUN);

    // All four previous words depend only on the current window, so they are
    // generated in parallel; at RK12 only the first two are consumed.
    for (genvar i = 0; i < 4; i++) begin : g_word
        aes_inv_word_gen_192 u_gen (
            .j     (k + 6'(5 - i)),
            .w_j   (window[5 - i]),
            .w_jm1 (window[4 - i]),
            .w_jm6 (gen_w[i])
        );
    end

    // At RK12 the window starts at w46 (not a multiple of 4), so the step
    // back is only two words; afterwards every step is four words.
    always_comb begin
        if (round_idx == 4'd12) begin
            raw_key   = {gen_w[1], gen_w[0], window[0], window[1]};
            window_nx = {gen_w[1], gen_w[0], window[0], window[1], window[2], window[3]};
        end else begin
            raw_key   = {gen_w[3], gen_w[2], gen_w[1], gen_w[0]};
            window_nx = {gen_w[3], gen_w[2], gen_w[1], gen_w[0], window[0], window[1]};
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        key_nx   = round_key;
        idx_nx   = round_idx;
        valid_nx = key_valid;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    k_nx     = 6'd46;
                    key_nx   = last_key[127:0];
                    idx_nx   = 4'd12;
                    valid_nx = 1'b1;
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (round_idx == 4'd0) begin
                        state_nx = S_IDLE;
                        k_nx     = 6'd0;
                        key_nx   = '0;
                        idx_nx   = 4'd0;
                        valid_nx = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        k_nx   = (round_idx == 4'd12) ? 6'd44 : k - 6'd4;
                        idx_nx = round_idx - 4'd1;
`ifdef AES_INV_KEY_MIXCOL_EN
                        // Next index 11..1 gets InvMixColumns; RK0 stays raw.
                        if (round_idx >= 4'd2) begin
                            key_nx = {inv_mix_column(raw_key[127:96]),
                                      inv_mix_column(raw_key[95:64]),
                                      inv_mix_column(raw_key[63:32]),
                                      inv_mix_column(raw_key[31:0])};
                        end else begin
                            key_nx = raw_key;
                        end
`else
                        key_nx = raw_key;
`endif
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            window    <= '0;
            k         <= '0;
            round_key <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            k         <= k_nx;
            round_key <= key_nx;
            round_idx <= idx_nx;
            key_valid <= valid_nx;
            done      <= done_nx;
            if (state == S_IDLE && start) begin
                window <= last_key;
            end else if (fire && round_idx == 4'd0) begin
                window <= '0;
            end else if (fire) begin
                window <= window_nx;
            end
        end
    end

endmodule
